f1_light_seq: RTL

//   Parametrised F1 start-light sequencer with integrated tick divider. On a trigger,

---
 rtl/f1_light_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: built-in tick divider, lamp fill, random or fixed hold, done pulse.
// All outputs come straight from registers; the free-running LFSR supplies the hold length.
module f1_light_seq #(
   parameter int WIDTH      = 8,
   parameter int N_WIDTH    = 16,
   parameter int LFSR_WIDTH = 7,
   parameter int FIXED_HOLD = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               trigger,
   input  logic               abort,
   input  logic [N_WIDTH-1:0] N,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy,
   output logic               done
);

   localparam int FH_W   = $clog2(FIXED_HOLD + 1);
   localparam int HOLD_W = (LFSR_WIDTH > FH_W) ? LFSR_WIDTH : FH_W;

   // Maximal-length Fibonacci tap masks (bit k-1 set for tap k)
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         default: return 32'h00E1_0000;
      endcase
   endfunction

   localparam logic [31:0] TAPS = lfsr_taps(LFSR_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

   state_t               r_state, w_state_nx;
   logic [N_WIDTH-1:0]   r_cnt, w_cnt_nx;
   logic [WIDTH-1:0]     r_data, w_data_nx;
   logic [HOLD_W-1:0]    r_hold, w_hold_nx;
   logic [LFSR_WIDTH-1:0] r_lfsr;
   logic                 r_busy, r_done, w_done_nx;
   logic                 w_tick, w_fb;

   assign w_tick   = en && (r_cnt == '0);
   assign w_fb     = ^(r_lfsr & TAPS[LFSR_WIDTH-1:0]);
   assign data_out = r_data;
   assign busy     = r_busy;
   assign done     = r_done;

   always_comb begin
      w_state_nx = r_state;
      w_data_nx  = r_data;
      w_hold_nx  = r_hold;
      w_done_nx  = 1'b0;
      w_cnt_nx   = r_cnt;
      if (w_tick)
         w_cnt_nx = N;
      else if (en)
         w_cnt_nx = r_cnt - N_WIDTH'(1);

      if (abort) begin
         w_state_nx = S_IDLE;
         w_data_nx  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_data_nx = '0;
               // Restart the divider so the first lamp is a full period away
               if (en && trigger) begin
                  w_state_nx = S_FILL;
                  w_cnt_nx   = N;
               end
            end
            S_FILL: begin
               if (w_tick) begin
                  w_data_nx = {r_data[WIDTH-2:0], 1'b1};
                  if (r_data[WIDTH-2:0] == '1) begin
                     w_state_nx = S_HOLD;
                     w_hold_nx  = (FIXED_HOLD != 0) ? HOLD_W'(FIXED_HOLD) : HOLD_W'(r_lfsr);
                  end
               end
            end
            S_HOLD: begin
               if (w_tick) begin
                  w_hold_nx = r_hold - HOLD_W'(1);
                  if (r_hold == HOLD_W'(1)) begin
                     w_data_nx  = '0;
                     w_done_nx  = 1'b1;
                     w_state_nx = S_IDLE;
                  end
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_data_nx  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_hold  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_data  <= w_data_nx;
         r_hold  <= w_hold_nx;
         r_busy  <= (w_state_nx != S_IDLE);
         r_done  <= w_done_nx;
      end
   end

   // Runs on every clock regardless of en so the hold length is unpredictable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_lfsr <= LFSR_WIDTH'(1);
      else
         r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], w_fb};
   end

endmodule
